// File: rtl/zbuffer_ztest.sv
`default_nettype none
// ============================================================================
// Module   : zbuffer_ztest
// Purpose  : Depth buffer with an integrated depth test. Fragments (row, col,
//            z) arrive on a valid/ready handshake. Each one is compared against
//            the stored depth with a selectable function. When it passes and
//            depth writes are enabled, the new depth is written back. The
//            pass/fail result is then emitted downstream. A clear engine
//            sweeps the whole buffer to a programmable value.
// Ports    : clk, rstn (sync, active low)
//            i_clear, i_clear_val, o_clear_busy  - clear engine control
//            i_valid, o_ready, i_row, i_col, i_z,
//            i_func, i_zwrite                    - fragment input
//            o_valid, i_ready, o_pass, o_row,
//            o_col, o_z                          - result output
//            o_pass_cnt, o_fail_cnt              - only with ZBUF_STATS_EN
// Options  : `define ZBUF_STATS_EN adds saturating pass/fail result counters.
// Revision : 1.0 - initial release
// ============================================================================
module zbuffer_ztest #(
    parameter int COLS          = 640,
    parameter int ROWS          = 480,
    parameter int DEPTH_W       = 22,
    parameter int CLEAR_PER_CYC = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_clear,
    input  logic [DEPTH_W-1:0]        i_clear_val,
    output logic                      o_clear_busy,
    input  logic [1:0]                i_func,
    input  logic                      i_zwrite,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [$clog2(ROWS)-1:0]   i_row,
    input  logic [$clog2(COLS)-1:0]   i_col,
    input  logic [DEPTH_W-1:0]        i_z,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_pass,
    output logic [$clog2(ROWS)-1:0]   o_row,
    output logic [$clog2(COLS)-1:0]   o_col,
    output logic [DEPTH_W-1:0]        o_z
`ifdef ZBUF_STATS_EN
    ,
    output logic [31:0]               o_pass_cnt,
    output logic [31:0]               o_fail_cnt
`endif
);

    localparam int c_row_w  = $clog2(ROWS);
    localparam int c_col_w  = $clog2(COLS);
    localparam int c_words  = ROWS * COLS;
    localparam int c_addr_w = $clog2(c_words);

    localparam logic [c_row_w:0]    c_rows_ext = (c_row_w + 1)'(ROWS);
    localparam logic [c_col_w:0]    c_cols_ext = (c_col_w + 1)'(COLS);
    localparam logic [c_addr_w-1:0] c_clr_last = c_addr_w'(c_words - CLEAR_PER_CYC);
    localparam logic [c_addr_w-1:0] c_clr_step = c_addr_w'(CLEAR_PER_CYC);

    localparam logic [1:0] c_f_less   = 2'd0;
    localparam logic [1:0] c_f_lequal = 2'd1;
    localparam logic [1:0] c_f_always = 2'd2;
    localparam logic [1:0] c_f_never  = 2'd3;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_drain = 2'd1;
    localparam logic [1:0] c_st_clear = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DEPTH_W-1:0]  r_mem [0:c_words-1];
    logic [DEPTH_W-1:0]  r_rd_data;

    logic [1:0]          r_state;
    logic [c_addr_w-1:0] r_clr_addr;
    logic [DEPTH_W-1:0]  r_clr_val;

    logic                r_s1_valid;
    logic [c_row_w-1:0]  r_s1_row;
    logic [c_col_w-1:0]  r_s1_col;
    logic [DEPTH_W-1:0]  r_s1_z;
    logic [1:0]          r_s1_func;
    logic                r_s1_zwrite;
    logic                r_s1_inrange;
    logic [c_addr_w-1:0] r_s1_addr;
    logic                r_s1_fwd;
    logic [DEPTH_W-1:0]  r_s1_fwd_z;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic                w_adv;
    logic                w_clear_start;
    logic                w_accept;
    logic                w_s0_inrange;
    logic [c_addr_w-1:0] w_s0_addr;
    logic                w_rd_en;
    logic [c_addr_w-1:0] w_rd_addr;
    logic [DEPTH_W-1:0]  w_stored;
    logic                w_pass;
    logic                w_wr_en;

    assign w_adv         = ~o_valid | i_ready;
    assign o_ready       = w_adv & (r_state == c_st_idle);
    assign w_clear_start = (r_state == c_st_idle) & i_clear;
    // A clear request wins over a fragment offered in the same cycle.
    assign w_accept      = i_valid & o_ready & ~w_clear_start;

    assign w_s0_inrange = ({1'b0, i_row} < c_rows_ext) && ({1'b0, i_col} < c_cols_ext);
    assign w_s0_addr    = c_addr_w'(i_row) * c_addr_w'(COLS) + c_addr_w'(i_col);

    // While stalled the S1 address is read again so the S1 read data stays
    // valid; S1 does not write while stalled, so the re-read is coherent.
    assign w_rd_en   = w_adv ? (w_accept & w_s0_inrange) : (r_s1_valid & r_s1_inrange);
    assign w_rd_addr = w_adv ? w_s0_addr : r_s1_addr;

    assign w_stored = r_s1_fwd ? r_s1_fwd_z : r_rd_data;

    always_comb begin
        w_pass = 1'b0;
        case (r_s1_func)
            c_f_less:   w_pass = (r_s1_z <  w_stored);
            c_f_lequal: w_pass = (r_s1_z <= w_stored);
            c_f_always: w_pass = 1'b1;
            c_f_never:  w_pass = 1'b0;
            default:    w_pass = 1'b0;
        endcase
        if (!r_s1_inrange) begin
            w_pass = 1'b0;
        end
    end

    assign w_wr_en = w_adv & r_s1_valid & r_s1_inrange & w_pass & r_s1_zwrite;

    // ------------------------------------------------------------------------
    // Depth storage: one read port, one write port (shared by the clear sweep,
    // which only runs while S1 is empty).
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (r_state == c_st_clear) begin
            for (int k = 0; k < CLEAR_PER_CYC; k++) begin
                r_mem[r_clr_addr + c_addr_w'(k)] <= r_clr_val;
            end
        end else if (w_wr_en) begin
            r_mem[r_s1_addr] <= r_s1_z;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rd_en) begin
            r_rd_data <= r_mem[w_rd_addr];
        end
    end

    // ------------------------------------------------------------------------
    // Clear engine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= c_st_idle;
            o_clear_busy <= 1'b0;
            r_clr_addr   <= '0;
            r_clr_val    <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (i_clear) begin
                        r_clr_val    <= i_clear_val;
                        r_clr_addr   <= '0;
                        r_state      <= c_st_drain;
                        o_clear_busy <= 1'b1;
                    end
                end
                c_st_drain: begin
                    // o_ready is low here, so only S1 can still hold work.
                    if (!r_s1_valid) begin
                        r_state <= c_st_clear;
                    end
                end
                c_st_clear: begin
                    if (r_clr_addr == c_clr_last) begin
                        r_state      <= c_st_idle;
                        o_clear_busy <= 1'b0;
                    end else begin
                        r_clr_addr <= r_clr_addr + c_clr_step;
                    end
                end
                default: begin
                    r_state      <= c_st_idle;
                    o_clear_busy <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Pipeline: S1 (read data / compare) and S2 (output register)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s1_row     <= i_row;
            r_s1_col     <= i_col;
            r_s1_z       <= i_z;
            r_s1_func    <= i_func;
            r_s1_zwrite  <= i_zwrite;
            r_s1_inrange <= w_s0_inrange;
            r_s1_addr    <= w_s0_addr;
            // The memory read issued this cycle cannot see the write landing
            // on the same edge, so capture that depth for the next compare.
            r_s1_fwd     <= w_wr_en && (w_s0_addr == r_s1_addr);
            r_s1_fwd_z   <= r_s1_z;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_s1_valid <= 1'b0;
            o_valid    <= 1'b0;
            o_pass     <= 1'b0;
            o_row      <= '0;
            o_col      <= '0;
            o_z        <= '0;
        end else if (w_adv) begin
            r_s1_valid <= w_accept;
            o_valid    <= r_s1_valid;
            if (r_s1_valid) begin
                o_pass <= w_pass;
                o_row  <= r_s1_row;
                o_col  <= r_s1_col;
                o_z    <= r_s1_z;
            end
        end
    end

`ifdef ZBUF_STATS_EN
    // ------------------------------------------------------------------------
    // Saturating counters of consumed results
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn || w_clear_start) begin
            o_pass_cnt <= '0;
            o_fail_cnt <= '0;
        end else if (o_valid && i_ready) begin
            if (o_pass) begin
                if (o_pass_cnt != '1) begin
                    o_pass_cnt <= o_pass_cnt + 32'd1;
                end
            end else begin
                if (o_fail_cnt != '1) begin
                    o_fail_cnt <= o_fail_cnt + 32'd1;
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_zbuffer_ztest.sv
`default_nettype none
// ============================================================================
// Module   : tb_zbuffer_ztest
// Purpose  : Directed self-checking bench for zbuffer_ztest on a small 6x8
//            buffer with two clear writes per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zbuffer_ztest;

    localparam int COLS    = 8;
    localparam int ROWS    = 6;
    localparam int DEPTH_W = 22;
    localparam int CPC     = 2;
    localparam int RW      = $clog2(ROWS);
    localparam int CW      = $clog2(COLS);

    localparam logic [1:0] c_less   = 2'd0;
    localparam logic [1:0] c_lequal = 2'd1;
    localparam logic [1:0] c_always = 2'd2;
    localparam logic [1:0] c_never  = 2'd3;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               i_clear = 1'b0;
    logic [DEPTH_W-1:0] i_clear_val = '0;
    logic               o_clear_busy;
    logic [1:0]         i_func = '0;
    logic               i_zwrite = 1'b0;
    logic               i_valid = 1'b0;
    logic               o_ready;
    logic [RW-1:0]      i_row = '0;
    logic [CW-1:0]      i_col = '0;
    logic [DEPTH_W-1:0] i_z = '0;
    logic               o_valid;
    logic               i_ready = 1'b1;
    logic               o_pass;
    logic [RW-1:0]      o_row;
    logic [CW-1:0]      o_col;
    logic [DEPTH_W-1:0] o_z;
`ifdef ZBUF_STATS_EN
    logic [31:0]        o_pass_cnt;
    logic [31:0]        o_fail_cnt;
`endif

    always #5 clk = ~clk;

    zbuffer_ztest #(
        .COLS(COLS), .ROWS(ROWS), .DEPTH_W(DEPTH_W), .CLEAR_PER_CYC(CPC)
    ) dut (
        .clk(clk), .rstn(rstn),
        .i_clear(i_clear), .i_clear_val(i_clear_val), .o_clear_busy(o_clear_busy),
        .i_func(i_func), .i_zwrite(i_zwrite),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_row(i_row), .i_col(i_col), .i_z(i_z),
        .o_valid(o_valid), .i_ready(i_ready), .o_pass(o_pass),
        .o_row(o_row), .o_col(o_col), .o_z(o_z)
`ifdef ZBUF_STATS_EN
        , .o_pass_cnt(o_pass_cnt), .o_fail_cnt(o_fail_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic p, input logic [RW-1:0] r,
                                       input logic [CW-1:0] c, input logic [DEPTH_W-1:0] z);
        return {35'd0, p, r, c, z};
    endfunction

    // Result monitor: records every consumed result and checks that a stalled
    // result stays put until it is taken.
    logic [63:0] res_q[$];
    logic        r_stalled = 1'b0;
    logic [63:0] r_held = '0;

    always @(negedge clk) begin
        if (rstn) begin
            if (r_stalled) begin
                check_eq("hold_valid", {63'd0, o_valid}, 64'd1);
                check_eq("hold_data", pk(o_pass, o_row, o_col, o_z), r_held);
            end
            if (o_valid && i_ready) res_q.push_back(pk(o_pass, o_row, o_col, o_z));
            r_stalled = o_valid && !i_ready;
            r_held    = pk(o_pass, o_row, o_col, o_z);
        end else begin
            r_stalled = 1'b0;
        end
    end

    task automatic push(input logic [RW-1:0] r, input logic [CW-1:0] c,
                        input logic [DEPTH_W-1:0] z, input logic [1:0] f, input logic zw);
        int n = 0;
        @(negedge clk);
        i_valid = 1'b1; i_row = r; i_col = c; i_z = z; i_func = f; i_zwrite = zw;
        while (!o_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) check_eq("push_ready", {63'd0, o_ready}, 64'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic p, input logic [RW-1:0] r,
                              input logic [CW-1:0] c, input logic [DEPTH_W-1:0] z);
        int n = 0;
        while (res_q.size() == 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (res_q.size() == 0) check_eq({tag, "_timeout"}, 64'(res_q.size()), 64'd1);
        else check_eq(tag, res_q.pop_front(), pk(p, r, c, z));
    endtask

    task automatic do_clear(input logic [DEPTH_W-1:0] v, input int exp_len);
        int n = 0;
        @(negedge clk);
        i_clear = 1'b1; i_clear_val = v;
        @(posedge clk);
        #1;
        i_clear = 1'b0;
        check_eq("busy_rise", {63'd0, o_clear_busy}, 64'd1);
`ifdef ZBUF_STATS_EN
        check_eq("pass_cnt_clr", {32'd0, o_pass_cnt}, 64'd0);
        check_eq("fail_cnt_clr", {32'd0, o_fail_cnt}, 64'd0);
`endif
        while (o_clear_busy && n < 200) begin
            check_eq("ready_low_busy", {63'd0, o_ready}, 64'd0);
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("busy_fall", {63'd0, o_clear_busy}, 64'd0);
        check_eq("busy_len", 64'(n), 64'(exp_len));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", {63'd0, o_valid}, 64'd0);
        check_eq("rst_pass",  {63'd0, o_pass}, 64'd0);
        check_eq("rst_data",  pk(1'b0, o_row, o_col, o_z), 64'd0);
        check_eq("rst_busy",  {63'd0, o_clear_busy}, 64'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_ready", {63'd0, o_ready}, 64'd1);

        // ---------------- clear and readback ----------------
        do_clear(22'h3FFFFF, 1 + ROWS * COLS / CPC);
        push(0, 0, 100, c_less, 1'b1);
        check_eq("lat_cyc1", {63'd0, o_valid}, 64'd0);
        @(posedge clk);
        #1;
        check_eq("lat_cyc2", {62'd0, o_valid, o_pass}, 64'd3);
        expect_res("rb_less_w", 1'b1, 0, 0, 100);
        push(0, 0, 100, c_less, 1'b0);
        push(0, 0, 100, c_lequal, 1'b0);
        expect_res("rb_less_eq", 1'b0, 0, 0, 100);
        expect_res("rb_lequal",  1'b1, 0, 0, 100);

        // ---------------- forwarding ----------------
        push(5, 7, 50, c_less, 1'b1);
        push(5, 7, 60, c_less, 1'b1);
        push(5, 7, 40, c_less, 1'b1);
        push(5, 7, 45, c_less, 1'b1);
        push(5, 7, 30, c_less, 1'b1);
        push(5, 7, 30, c_lequal, 1'b0);
        push(5, 7, 30, c_less, 1'b0);
        expect_res("fw_50", 1'b1, 5, 7, 50);
        expect_res("fw_60", 1'b0, 5, 7, 60);
        expect_res("fw_40", 1'b1, 5, 7, 40);
        expect_res("fw_45", 1'b0, 5, 7, 45);
        expect_res("fw_30", 1'b1, 5, 7, 30);
        expect_res("fw_30le", 1'b1, 5, 7, 30);
        expect_res("fw_30lt", 1'b0, 5, 7, 30);

        // ---------------- backpressure ----------------
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    @(posedge clk);
                    #1;
                    i_ready = pat[k % 4];
                end
                i_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 8; i++) push(2, CW'(i), DEPTH_W'(1000 + i), c_less, 1'b1);
            end
        join
        for (int i = 0; i < 8; i++) expect_res("bp_order", 1'b1, 2, CW'(i), DEPTH_W'(1000 + i));
        repeat (4) @(posedge clk);
        #1;
        check_eq("bp_no_dup", 64'(res_q.size()), 64'd0);

        // ---------------- compare functions ----------------
        push(3, 3, 200, c_less,   1'b1);
        push(3, 3, 300, c_always, 1'b0);
        push(3, 3, 250, c_less,   1'b0);
        push(3, 3, 0,   c_never,  1'b1);
        push(3, 3, 200, c_lequal, 1'b0);
        push(3, 3, 199, c_less,   1'b0);
        expect_res("fn_w200",   1'b1, 3, 3, 200);
        expect_res("fn_always", 1'b1, 3, 3, 300);
        expect_res("fn_keep",   1'b0, 3, 3, 250);
        expect_res("fn_never",  1'b0, 3, 3, 0);
        expect_res("fn_le200",  1'b1, 3, 3, 200);
        expect_res("fn_lt199",  1'b1, 3, 3, 199);

        // ---------------- out of range ----------------
        push(6, 0, 0, c_always, 1'b1);
        push(7, 7, 0, c_always, 1'b1);
        push(0, 0, 100, c_lequal, 1'b0);
        push(0, 0, 99, c_less, 1'b0);
        push(5, 7, 30, c_lequal, 1'b0);
        expect_res("oor_row6", 1'b0, 6, 0, 0);
        expect_res("oor_row7", 1'b0, 7, 7, 0);
        expect_res("oor_keep00", 1'b1, 0, 0, 100);
        expect_res("oor_keep00b", 1'b1, 0, 0, 99);
        expect_res("oor_keep57", 1'b1, 5, 7, 30);

        // ---------------- clear during traffic ----------------
        push(1, 0, 10, c_always, 1'b1);
        push(1, 1, 20, c_always, 1'b1);
        do_clear(22'h00ABCD, 1 + ROWS * COLS / CPC);
        expect_res("clr_fl0", 1'b1, 1, 0, 10);
        expect_res("clr_fl1", 1'b1, 1, 1, 20);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                push(RW'(r), CW'(c), 22'h00ABCD, c_lequal, 1'b0);
                push(RW'(r), CW'(c), 22'h00ABCD, c_less, 1'b0);
                expect_res("clr_le", 1'b1, RW'(r), CW'(c), 22'h00ABCD);
                expect_res("clr_lt", 1'b0, RW'(r), CW'(c), 22'h00ABCD);
            end
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/zbuffer_ztest.md
Name: zbuffer_ztest

Overview:
- Parametrised depth buffer with an integrated depth test. Generalises the plain read-only depth store.
- Accepts rasterised fragments (row, col, z) through a valid/ready handshake and reads the stored depth. It compares the fragment depth under a selectable compare function and conditionally writes the new depth back.
- Emits the pass/fail result downstream to the pixel shader/colour writer.
- Contains a clear engine that sweeps the whole buffer to a programmable clear value.

Parameters:
- COLS, 640, buffer width in pixels.
- ROWS, 480, buffer height in pixels.
- DEPTH_W, 22, depth word width in bits (unsigned).
- CLEAR_PER_CYC, 1, words written per cycle during a clear; must divide COLS.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rstn  input  1  synchronous active-low reset.
- i_clear  input  1  pulse: start a clear (ignored while a clear is busy).
- i_clear_val  input  DEPTH_W  clear value, sampled on the i_clear cycle.
- o_clear_busy  output  1  high from the cycle after i_clear until the last clear write.
- i_func  input  2  compare function: 0 LESS, 1 LEQUAL, 2 ALWAYS, 3 NEVER. Sampled with each fragment.
- i_zwrite  input  1  write enable on pass. Sampled with each fragment.
- i_valid  input  1  fragment valid.
- o_ready  output  1  fragment ready.
- i_row  input  $clog2(ROWS)  fragment row.
- i_col  input  $clog2(COLS)  fragment column.
- i_z  input  DEPTH_W  fragment depth.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream ready.
- o_pass  output  1  depth test result.
- o_row  output  $clog2(ROWS)  echoed row.
- o_col  output  $clog2(COLS)  echoed column.
- o_z  output  DEPTH_W  echoed fragment depth.

Behaviour:
- Reset (rstn low at clk edge):
  - o_valid=0, o_pass=0, o_row/o_col/o_z=0, o_clear_busy=0.
  - Pipeline stages empty; FSM in IDLE.
  - Memory contents are undefined after reset; software must issue a clear.
- Storage:
  - ROWS*COLS words of DEPTH_W bits, addressed row*COLS+col.
  - Synchronous read, one read port and one write port.
- Handshakes:
  - Fragment accepted when i_valid & o_ready.
  - Result consumed when o_valid & i_ready.
  - o_valid and output data hold stable until consumed.
- Pipeline (3 stages):
  - S0 accept/read issue, S1 read data/compare, S2 output register.
  - Latency from accept to o_valid is 2 cycles with no stall.
  - Throughput is 1 fragment/cycle.
  - Advance condition: adv = ~o_valid | i_ready. When adv=0 all stages hold, and the read address is re-presented so S1 data stays valid.
  - o_ready = adv & (state==IDLE).
- Compare and write (in S1):
  - stored = forwarded-or-read depth.
  - pass = LESS: z<stored; LEQUAL: z<=stored; ALWAYS: 1; NEVER: 0. Comparison is unsigned.
  - Write z to the address when pass & zwrite, in the cycle S1 advances to S2.
- Hazard:
  - If S1 writes address A while the fragment entering S1 reads A, the written z is forwarded instead of the stale memory data.
  - Back-to-back same-pixel fragments must therefore behave as if strictly sequential.
- Out-of-range coordinates (row>=ROWS or col>=COLS):
  - pass forced 0, no write, no memory access.
  - Fragment still produces a result.
- Clear FSM:
  - IDLE: on i_clear, latch i_clear_val, address=0, go to DRAIN.
  - DRAIN: wait until S0 and S1 are empty (S2 may still hold a result), then go to CLEAR.
  - CLEAR: write CLEAR_PER_CYC words per cycle, address incremented by CLEAR_PER_CYC. At the last address go to IDLE.
  - o_clear_busy is high in DRAIN and CLEAR.
  - A fragment presented in the i_clear cycle is not accepted (o_ready drops the following cycle; i_clear takes priority in the same cycle).
- Reset mid-clear or mid-pipeline: all control returns to the reset values. Partial clear contents are undefined.

Optional Feature:
- Macro ZBUF_STATS_EN.
- When defined, adds output ports o_pass_cnt[31:0] and o_fail_cnt[31:0]:
  - Saturating counts of results consumed with pass=1 and pass=0 respectively.
  - Reset to 0 by rstn and by the start of a clear.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Clear and readback: clear with 22'h3FFFFF, wait until o_clear_busy falls. Then fragment (0,0,z=100,LESS,zwrite=1) -> o_pass=1 two cycles after accept. Fragment (0,0,z=100,LESS) -> o_pass=0; same with LEQUAL -> o_pass=1.
- Forwarding: back-to-back same pixel (5,7), z=50 then z=60 under LESS, no stall -> pass=1 then pass=0. Fragment z=40 -> pass=1.
- Backpressure: stream 8 fragments with i_ready toggling 1,0,0,1 -> results in order, no loss or duplication, outputs stable while stalled.
- Compare functions: stored 200 after clear+write, z=300 with ALWAYS, zwrite=0 -> pass=1, stored stays 200 (verify with z=250 LESS -> pass=0). NEVER z=0 -> pass=0.
- Out-of-range: row=ROWS, z=0, ALWAYS -> pass=0, no memory change at any address.
- Clear during traffic: assert i_clear with 2 fragments in flight -> both results emitted, o_ready low until the clear finishes after ROWS*COLS/CLEAR_PER_CYC cycles, then every pixel reads the clear value. With ZBUF_STATS_EN, the counters read 0 after the clear starts.
